uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001: Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 1..65535.
- REQ-002: Parameter DATA_BITS, default 8, data bits per frame; legal range 5..8.
- REQ-003: clk  input  1  single clock; all state changes on posedge clk.
- REQ-004: rstn  input  1  reset, asynchronous and active-low.
- REQ-005: tx_valid  input  1  tx_data holds a byte to send.
- REQ-006: tx_data  input  DATA_BITS  parallel byte to serialise.
- REQ-007: tx_ready  output  1  block can accept a byte this cycle.
- REQ-008: txd  output  1  serial line, idle high, registered.
- REQ-009: tx_done  output  1  one-cycle pulse when a frame completes.

Function
- REQ-010: FSM states are IDLE, START, DATA and STOP.
- REQ-011: tx_ready SHALL be 1 exactly when state is IDLE.
- REQ-012: A transfer SHALL occur on a posedge with tx_valid=1 and tx_ready=1; tx_data is latched into a shift register; state moves to START.
- REQ-013: START: txd=0 for CLKS_PER_BIT cycles, starting at the accepting edge.
- REQ-014: DATA: DATA_BITS bits, LSB first, each held CLKS_PER_BIT cycles.
- REQ-015: STOP: txd=1 for CLKS_PER_BIT cycles; then state IDLE.
- REQ-016: tx_done SHALL be 1 for exactly the first cycle in IDLE after STOP, and 0 otherwise.
- REQ-017: Frame length SHALL be (DATA_BITS+2)*CLKS_PER_BIT cycles from the accepting edge to re-entry into IDLE.
- REQ-018: With tx_valid held high, consecutive frames SHALL be separated by exactly one IDLE cycle with txd=1. The next byte is accepted on that cycle, coincident with tx_done.
- REQ-019: tx_data and tx_valid changes while not in IDLE SHALL have no effect on the frame in progress.
- REQ-020: Baud counter SHALL count 0..CLKS_PER_BIT-1, reset to 0 on each state entry, and wrap without overflow. With CLKS_PER_BIT=1 every cycle is a bit boundary.
- REQ-021: The data bit index SHALL count 0..DATA_BITS-1. DATA exits after index DATA_BITS-1 completes.
- REQ-022: txd SHALL be 1 in IDLE at all times, including while tx_valid=0.

Reset
- REQ-023: rstn=0 SHALL immediately force state IDLE, txd=1, tx_ready=1, tx_done=0, counters 0 and shift register 0, independent of clk.
- REQ-024: Reset asserted mid-frame SHALL abandon the frame without a tx_done pulse. The first acceptance is possible on the first posedge after rstn rises.

Structure
- REQ-025: Package uart_pkg SHALL hold the FSM state typedef (IDLE, START, DATA, STOP), the default CLKS_PER_BIT and the default DATA_BITS constants.
- REQ-026: Baud timing SHALL live in sub-module uart_baud_cnt, which has clk, rstn, a clear input and a bit_end output pulse. The FSM, shift register and outputs stay in uart_tx.

Verification (CLKS_PER_BIT=4, DATA_BITS=8 unless stated)
- REQ-027: Reset held low 3 cycles, tx_valid=1 -> txd=1, tx_ready=1, tx_done=0 throughout; no acceptance.
- REQ-028: Send 0xA5 -> txd = 0,1,0,1,0,0,1,0,1,1 (start, bits, stop), each bit 4 cycles; tx_done pulses once, 40 cycles after the accepting edge.
- REQ-029: 0x00 then 0xFF with tx_valid held high -> second start bit begins exactly 41 cycles after the first; a single 1-cycle idle high gap; two tx_done pulses.
- REQ-030: rstn pulsed low during DATA bit 3 -> txd=1 within the same cycle; no tx_done; a fresh 0x3C after release transmits correctly.
- REQ-031: tx_data changed from 0x55 to 0xAA mid-frame -> serial output is still 0x55.
- REQ-032: CLKS_PER_BIT=1, send 0x3C -> txd = 0,0,0,1,1,1,1,0,0,1 on 10 consecutive cycles; tx_done on the 11th.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encoding and default parameters for the UART transmitter
package uart_pkg;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t IDLE  = 2'd0;
  localparam uart_state_t START = 2'd1;
  localparam uart_state_t DATA  = 2'd2;
  localparam uart_state_t STOP  = 2'd3;

  localparam int DEFAULT_CLKS_PER_BIT = 4;
  localparam int DEFAULT_DATA_BITS    = 8;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter; bit_end marks the last clock of each serial bit
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic bit_end
);

  logic [15:0] r_cnt;
  logic        w_bit_end;

  // Wrapping at the bit end doubles as the reset on every state entry.
  assign w_bit_end = (r_cnt == 16'(CLKS_PER_BIT - 1));
  assign bit_end   = w_bit_end;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (clear || w_bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: valid/ready byte intake, 8N1-style framing, registered txd
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_done
);

  uart_state_t          r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [2:0]           r_bit_idx;
  logic                 r_txd;
  logic                 r_tx_done;
  logic                 w_bit_end;
  logic                 w_clear;
  logic                 w_last_bit;

  // Holding the counter clear in IDLE makes START begin from zero at the accepting edge.
  assign w_clear    = (r_state == IDLE);
  assign w_last_bit = (r_bit_idx == 3'(DATA_BITS - 1));

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (w_clear),
    .bit_end(w_bit_end)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_txd     <= 1'b1;
      r_tx_done <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_txd <= 1'b1;
          if (tx_valid) begin
            r_shift   <= tx_data;
            r_bit_idx <= '0;
            r_txd     <= 1'b0;
            r_state   <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_txd   <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (w_last_bit) begin
              r_txd     <= 1'b1;
              r_bit_idx <= '0;
              r_state   <= STOP;
            end else begin
              r_txd     <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_tx_done <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready = (r_state == IDLE);
  assign txd      = r_txd;
  assign tx_done  = r_tx_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx at 4 and 1 clocks per bit
module tb_uart_tx;

  logic       clk       = 1'b0;
  logic       rstn      = 1'b1;
  logic       tx_valid  = 1'b0;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_ready;
  logic       txd;
  logic       tx_done;
  logic       tx_valid1 = 1'b0;
  logic [7:0] tx_data1  = 8'h00;
  logic       tx_ready1;
  logic       txd1;
  logic       tx_done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .txd     (txd),
    .tx_done (tx_done)
  );

  uart_tx #(.CLKS_PER_BIT(1), .DATA_BITS(8)) dut1 (
    .clk     (clk),
    .rstn    (rstn),
    .tx_valid(tx_valid1),
    .tx_data (tx_data1),
    .tx_ready(tx_ready1),
    .txd     (txd1),
    .tx_done (tx_done1)
  );

  task automatic test_reset();
    rstn = 1'b0; tx_valid = 1'b1; tx_data = 8'hFF; tx_valid1 = 1'b1; tx_data1 = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (txd !== 1'b1 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: txd=%b ready=%b done=%b, required 1 1 0", i, txd, tx_ready, tx_done);
      end
      checks++;
      if (txd1 !== 1'b1 || tx_ready1 !== 1'b1 || tx_done1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_cpb1[%0d]: txd=%b ready=%b done=%b, required 1 1 0", i, txd1, tx_ready1, tx_done1);
      end
    end
    rstn = 1'b1; tx_valid = 1'b0; tx_valid1 = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (txd !== 1'b1 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
        errors++;
        $display("FAIL idle[%0d]: txd=%b ready=%b done=%b, required 1 1 0", i, txd, tx_ready, tx_done);
      end
    end
  endtask

  // exp[k] is the k-th serial bit of the frame (start first, stop last).
  task automatic run_frame(input logic [7:0] data, input logic [9:0] exp, input int change_at,
                           input string name);
    logic exp_txd;
    logic exp_done;
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before: got %b, required 1", name, tx_ready);
    end
    tx_valid = 1'b1; tx_data = data;
    for (int n = 1; n <= 41; n++) begin
      @(negedge clk);
      if (n == 1) tx_valid = 1'b0;
      if (change_at != 0 && n == change_at) begin tx_data = 8'hAA; tx_valid = 1'b1; end
      if (change_at != 0 && n == change_at + 4) tx_valid = 1'b0;
      exp_txd  = (n <= 40) ? exp[(n-1)/4] : 1'b1;
      exp_done = (n == 41);
      checks++;
      if (txd !== exp_txd) begin
        errors++;
        $display("FAIL %s txd[cycle %0d]: got %b, required %b", name, n, txd, exp_txd);
      end
      checks++;
      if (tx_done !== exp_done) begin
        errors++;
        $display("FAIL %s tx_done[cycle %0d]: got %b, required %b", name, n, tx_done, exp_done);
      end
      checks++;
      if (tx_ready !== exp_done) begin
        errors++;
        $display("FAIL %s tx_ready[cycle %0d]: got %b, required %b", name, n, tx_ready, exp_done);
      end
    end
  endtask

  task automatic test_single();
    run_frame(8'hA5, 10'b1101001010, 0, "send_a5");
  endtask

  task automatic test_data_hold();
    run_frame(8'h55, 10'b1010101010, 10, "data_hold");
  endtask

  task automatic test_back_to_back();
    logic [9:0] e0;
    logic [9:0] e1;
    logic       exp_txd;
    logic       exp_done;
    logic       exp_ready;
    e0 = 10'b1000000000;
    e1 = 10'b1111111110;
    tx_valid = 1'b1; tx_data = 8'h00;
    for (int n = 1; n <= 83; n++) begin
      @(negedge clk);
      if (n == 1) tx_data = 8'hFF;
      if (n == 42) tx_valid = 1'b0;
      if (n <= 40) exp_txd = e0[(n-1)/4];
      else if (n >= 42 && n <= 81) exp_txd = e1[(n-42)/4];
      else exp_txd = 1'b1;
      exp_done  = (n == 41 || n == 82);
      exp_ready = (n == 41 || n >= 82);
      checks++;
      if (txd !== exp_txd) begin
        errors++;
        $display("FAIL b2b txd[cycle %0d]: got %b, required %b", n, txd, exp_txd);
      end
      checks++;
      if (tx_done !== exp_done) begin
        errors++;
        $display("FAIL b2b tx_done[cycle %0d]: got %b, required %b", n, tx_done, exp_done);
      end
      checks++;
      if (tx_ready !== exp_ready) begin
        errors++;
        $display("FAIL b2b tx_ready[cycle %0d]: got %b, required %b", n, tx_ready, exp_ready);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    tx_valid = 1'b1; tx_data = 8'h00;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (n == 1) tx_valid = 1'b0;
      checks++;
      if (txd !== (n > 40) || tx_done !== 1'b0) begin
        errors++;
        $display("FAIL midrst frame[cycle %0d]: txd=%b done=%b, required 0 0", n, txd, tx_done);
      end
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst async: txd=%b ready=%b done=%b, required 1 1 0", txd, tx_ready, tx_done);
    end
    @(negedge clk);
    checks++;
    if (txd !== 1'b1 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst held: txd=%b done=%b, required 1 0", txd, tx_done);
    end
    rstn = 1'b1;
    run_frame(8'h3C, 10'b1001111000, 0, "after_reset");
  endtask

  task automatic test_cpb1();
    logic [9:0] e;
    logic       exp_txd;
    e = 10'b1001111000;
    tx_valid1 = 1'b1; tx_data1 = 8'h3C;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) tx_valid1 = 1'b0;
      exp_txd = (n <= 10) ? e[n-1] : 1'b1;
      checks++;
      if (txd1 !== exp_txd) begin
        errors++;
        $display("FAIL cpb1 txd[cycle %0d]: got %b, required %b", n, txd1, exp_txd);
      end
      checks++;
      if (tx_done1 !== (n == 11)) begin
        errors++;
        $display("FAIL cpb1 tx_done[cycle %0d]: got %b, required %b", n, tx_done1, (n == 11));
      end
      checks++;
      if (tx_ready1 !== (n >= 11)) begin
        errors++;
        $display("FAIL cpb1 tx_ready[cycle %0d]: got %b, required %b", n, tx_ready1, (n >= 11));
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_data_hold();
    test_back_to_back();
    test_reset_mid_frame();
    test_cpb1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
